// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter and its wait timer.
// Holds state encodings, port-select codes and the saturating run-count helper.
package mem_port_arbiter_pkg;

    localparam int DEF_DATA_W         = 32;
    localparam int DEF_MAX_DATA_RUN   = 4;
    localparam int DEF_TIMEOUT_CYCLES = 255;
    localparam int TIMER_W            = 8;
    localparam int RUN_W              = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arbState_e;

    typedef enum logic {
        SEL_I = 1'b0,
        SEL_D = 1'b1
    } portSel_e;

    function automatic logic [RUN_W-1:0] satInc(input logic [RUN_W-1:0] value,
                                                input logic [RUN_W-1:0] limit);
        return (value >= limit) ? limit : value + 1'b1;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// 8-bit wait counter with clear/enable; expire is high while count == TIMEOUT_CYCLES-1.
// Count updates one cycle after enable; no backpressure, the owner decides when to clear.
module mem_wait_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    output logic [TIMER_W-1:0] count,
    output logic               expire
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count == TIMER_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Data-priority arbiter sharing one memory between fetch and data ports; 3 edges request-to-IDLE minimum.
// Requesters hold req until their one-cycle ready; memory stalls via memAck, aborted after TIMEOUT_CYCLES.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int MAX_DATA_RUN   = DEF_MAX_DATA_RUN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instructionReq,
    input  logic [DATA_W-1:0] instructionAddress,
    output logic [DATA_W-1:0] instructionBus,
    output logic              instructionReady,
    input  logic              dataReq,
    input  logic [DATA_W-1:0] dataAddress,
    input  logic              dataWE,
    input  logic [DATA_W-1:0] dataWrite,
    output logic [DATA_W-1:0] dataRead,
    output logic              dataReady,
    output logic              memReq,
    output logic [DATA_W-1:0] memAddress,
    output logic              memWE,
    output logic [DATA_W-1:0] memWriteData,
    input  logic [DATA_W-1:0] memReadData,
    input  logic              memAck,
    output logic              busError
);

    arbState_e         state, stateNxt;
    logic [RUN_W-1:0]  runCount, runNxt;
    logic              memReqNxt, memWENxt, iRdyNxt, dRdyNxt, errNxt;
    logic [DATA_W-1:0] memAddrNxt, memWDNxt, iBusNxt, dReadNxt;
    logic              timerClear, timerEn, timerExpire;
    logic [TIMER_W-1:0] waitCount;
    logic              dataWins;
    portSel_e          sel;

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) waitTimer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timerClear),
        .enable (timerEn),
        .count  (waitCount),
        .expire (timerExpire)
    );

    // Fetch overrides data only once data has won MAX_DATA_RUN grants in a row against it.
    assign dataWins = dataReq && !(instructionReq && (runCount == RUN_W'(MAX_DATA_RUN)));
    assign sel      = (state == BUSY_D) ? SEL_D : SEL_I;

    always_comb begin
        stateNxt   = state;
        runNxt     = runCount;
        memReqNxt  = memReq;
        memAddrNxt = memAddress;
        memWENxt   = memWE;
        memWDNxt   = memWriteData;
        iBusNxt    = instructionBus;
        dReadNxt   = dataRead;
        iRdyNxt    = 1'b0;
        dRdyNxt    = 1'b0;
        errNxt     = busError;
        timerClear = 1'b0;
        timerEn    = 1'b0;
        case (state)
            IDLE: begin
                if (dataWins) begin
                    stateNxt   = BUSY_D;
                    memReqNxt  = 1'b1;
                    memAddrNxt = dataAddress;
                    memWENxt   = dataWE;
                    memWDNxt   = dataWrite;
                    timerClear = 1'b1;
                    runNxt     = instructionReq ? satInc(runCount, RUN_W'(MAX_DATA_RUN)) : '0;
                end else if (instructionReq) begin
                    stateNxt   = BUSY_I;
                    memReqNxt  = 1'b1;
                    memAddrNxt = instructionAddress;
                    memWENxt   = 1'b0;
                    memWDNxt   = '0;
                    timerClear = 1'b1;
                    runNxt     = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (memAck || timerExpire) begin
                    stateNxt  = RESP;
                    memReqNxt = 1'b0;
                    if (!memAck) begin
                        errNxt = 1'b1;
                    end
                    if (sel == SEL_D) begin
                        dRdyNxt = 1'b1;
                        if (!memWE) begin
                            dReadNxt = memAck ? memReadData : '0;
                        end
                    end else begin
                        iRdyNxt = 1'b1;
                        iBusNxt = memAck ? memReadData : '0;
                    end
                end else begin
                    timerEn = 1'b1;
                end
            end
            RESP: begin
                stateNxt = IDLE;
            end
            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            runCount         <= '0;
            memReq           <= 1'b0;
            memAddress       <= '0;
            memWE            <= 1'b0;
            memWriteData     <= '0;
            instructionBus   <= '0;
            dataRead         <= '0;
            instructionReady <= 1'b0;
            dataReady        <= 1'b0;
            busError         <= 1'b0;
        end else begin
            state            <= stateNxt;
            runCount         <= runNxt;
            memReq           <= memReqNxt;
            memAddress       <= memAddrNxt;
            memWE            <= memWENxt;
            memWriteData     <= memWDNxt;
            instructionBus   <= iBusNxt;
            dataRead         <= dReadNxt;
            instructionReady <= iRdyNxt;
            dataReady        <= dRdyNxt;
            busError         <= errNxt;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-plus-random bench for mem_port_arbiter acting as both requesters and the memory.
// Expected values come from a transaction-level model of what each port should see.
module tb_mem_port_arbiter;

    localparam int DW     = 32;
    localparam int MAXRUN = 4;
    localparam int TMO    = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          instructionReq, dataReq, dataWE, memAck;
    logic [DW-1:0] instructionAddress, dataAddress, dataWrite, memReadData;
    logic [DW-1:0] instructionBus, dataRead, memAddress, memWriteData;
    logic          instructionReady, dataReady, memReq, memWE, busError;

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] mIBus, mDRead;
    logic          mErr;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DATA_W         (DW),
        .MAX_DATA_RUN   (MAXRUN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .instructionReq     (instructionReq),
        .instructionAddress (instructionAddress),
        .instructionBus     (instructionBus),
        .instructionReady   (instructionReady),
        .dataReq            (dataReq),
        .dataAddress        (dataAddress),
        .dataWE             (dataWE),
        .dataWrite          (dataWrite),
        .dataRead           (dataRead),
        .dataReady          (dataReady),
        .memReq             (memReq),
        .memAddress         (memAddress),
        .memWE              (memWE),
        .memWriteData       (memWriteData),
        .memReadData        (memReadData),
        .memAck             (memAck),
        .busError           (busError)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkQuiet(input string tag);
        check({tag, ".iRdy"}, 32'(instructionReady), 32'd0);
        check({tag, ".dRdy"}, 32'(dataReady), 32'd0);
        check({tag, ".memReq"}, 32'(memReq), 32'd0);
        check({tag, ".iBus"}, instructionBus, mIBus);
        check({tag, ".dRead"}, dataRead, mDRead);
        check({tag, ".busErr"}, 32'(busError), 32'(mErr));
    endtask

    // One lone transaction; memory acks on busy cycle ackDelay+1, or never when noAck is set.
    task automatic doTxn(input string tag, input bit isData, input bit we, input logic [DW-1:0] addr,
                         input logic [DW-1:0] wdata, input int ackDelay, input bit noAck,
                         input logic [DW-1:0] rdata);
        int busyCycles = 0;
        bit gotReady = 0;
        if (isData) begin
            dataReq = 1'b1; dataWE = we; dataAddress = addr; dataWrite = wdata;
        end else begin
            instructionReq = 1'b1; instructionAddress = addr;
        end
        for (int c = 0; c < 40 && !gotReady; c++) begin
            step();
            if (instructionReady || dataReady) begin
                gotReady = 1;
                memAck = 1'b0;
            end else if (memReq) begin
                busyCycles++;
                check({tag, ".memAddress"}, memAddress, addr);
                check({tag, ".memWE"}, 32'(memWE), 32'(isData && we));
                if (isData && we) check({tag, ".memWriteData"}, memWriteData, wdata);
                dataAddress = $urandom; dataWrite = $urandom; instructionAddress = $urandom;
                memAck = (!noAck && busyCycles == ackDelay + 1);
                memReadData = memAck ? rdata : $urandom;
            end
        end
        memAck = 1'b0;
        if (noAck) mErr = 1'b1;
        if (!isData) mIBus = noAck ? '0 : rdata;
        else if (!we) mDRead = noAck ? '0 : rdata;
        check({tag, ".gotReady"}, 32'(gotReady), 32'd1);
        check({tag, ".busyCycles"}, 32'(busyCycles), noAck ? 32'(TMO) : 32'(ackDelay + 1));
        check({tag, ".iRdy"}, 32'(instructionReady), 32'(!isData));
        check({tag, ".dRdy"}, 32'(dataReady), 32'(isData));
        check({tag, ".iBus"}, instructionBus, mIBus);
        check({tag, ".dRead"}, dataRead, mDRead);
        check({tag, ".busErr"}, 32'(busError), 32'(mErr));
        instructionReq = 1'b0;
        dataReq = 1'b0;
        step();
        checkQuiet({tag, ".after"});
    endtask

    task automatic spuriousAck(input string tag);
        memAck = 1'b1;
        memReadData = 32'hFFFF_FFFF;
        step();
        memAck = 1'b0;
        memReadData = '0;
        step();
        checkQuiet(tag);
    endtask

    initial begin
        int grants;
        bit winner;
        bit isD, we;
        logic [DW-1:0] rd;

        reset = 1'b0;
        instructionReq = 0; dataReq = 0; dataWE = 0; memAck = 0;
        instructionAddress = '0; dataAddress = '0; dataWrite = '0; memReadData = '0;
        mIBus = '0; mDRead = '0; mErr = 1'b0;
        #12;
        checkQuiet("reset");
        check("reset.memAddress", memAddress, 32'd0);
        check("reset.memWE", 32'(memWE), 32'd0);
        check("reset.memWriteData", memWriteData, 32'd0);
        #6 reset = 1'b1;
        step();
        checkQuiet("postReset");

        doTxn("fetch", 0, 0, 32'h10, 32'h0, 0, 0, 32'hDEAD_BEEF);
        doTxn("load", 1, 0, 32'h44, 32'h0, 2, 0, 32'hCAFE_F00D);
        doTxn("store", 1, 1, 32'h40, 32'h1234_5678, 0, 0, 32'h5555_AAAA);
        spuriousAck("spurious");

        // Both ports held: data wins MAXRUN times, then fetch once, repeating.
        instructionAddress = 32'h100; dataAddress = 32'h200; dataWE = 1'b0;
        instructionReq = 1'b1; dataReq = 1'b1;
        grants = 0;
        for (int c = 0; c < 200 && grants < 10; c++) begin
            step();
            if (memReq && !memAck) begin
                winner = (memAddress == 32'h200);
                check($sformatf("grant%0d", grants), 32'(winner),
                      32'((grants % (MAXRUN + 1)) != MAXRUN));
                rd = $urandom;
                memReadData = rd;
                memAck = 1'b1;
                if (winner) mDRead = rd; else mIBus = rd;
                grants++;
            end else begin
                memAck = 1'b0;
            end
        end
        check("grantCount", 32'(grants), 32'd10);
        step();
        memAck = 1'b0;
        instructionReq = 1'b0; dataReq = 1'b0;
        step();
        checkQuiet("afterGrants");

        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(3) == 0) spuriousAck($sformatf("rndSpur%0d", k));
            isD = 1'($urandom_range(1));
            we  = isD ? 1'($urandom_range(1)) : 1'b0;
            doTxn($sformatf("rnd%0d", k), isD, we, $urandom, $urandom, $urandom_range(5), 0, $urandom);
        end

        doTxn("timeout", 1, 0, 32'h80, 32'h0, 0, 1, 32'h0);
        for (int k = 0; k < 4; k++) begin
            isD = 1'($urandom_range(1));
            we  = isD ? 1'($urandom_range(1)) : 1'b0;
            doTxn($sformatf("postErr%0d", k), isD, we, $urandom, $urandom, $urandom_range(6), 0, $urandom);
        end

        // Asynchronous reset in the middle of a data transaction.
        dataReq = 1'b1; dataWE = 1'b0; dataAddress = 32'h300;
        for (int c = 0; c < 10 && !memReq; c++) step();
        check("midReset.busy", 32'(memReq), 32'd1);
        #3 reset = 1'b0;
        #1;
        mIBus = '0; mDRead = '0; mErr = 1'b0;
        checkQuiet("midReset");
        check("midReset.memAddress", memAddress, 32'd0);
        check("midReset.memWE", 32'(memWE), 32'd0);
        check("midReset.memWriteData", memWriteData, 32'd0);
        dataReq = 1'b0;
        step();
        step();
        checkQuiet("inReset");
        #3 reset = 1'b1;
        step();
        checkQuiet("releasedReset");
        doTxn("fetchAfterReset", 0, 0, 32'h20, 32'h0, 1, 0, 32'h0BAD_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
